// File: rtl/nios2_pio_led_blink.sv
// nios2_pio_led_blink: Avalon-MM output PIO for board LEDs with atomic
// set/clear writes and per-bit hardware blink on a programmable timer.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   address    word address (0 DATA, 1 BLINK_EN, 2 PERIOD, 3 OUTSET,
//              4 OUTCLR, 5 STATUS, 6/7 reserved)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data
//   readdata   combinational read data, zero-extended
//   out_port   registered LED outputs
module nios2_pio_led_blink #(
  parameter int unsigned WIDTH          = 6,
  parameter logic [31:0] RESET_VALUE    = 32'h0,
  parameter int unsigned PERIOD_W       = 24,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd2499999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0]    RST_DATA = RESET_VALUE[WIDTH-1:0];
  localparam logic [PERIOD_W-1:0] RST_PER  = DEFAULT_PERIOD[PERIOD_W-1:0];

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_BLINK  = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_OUTSET = 3'd3;
  localparam logic [2:0] A_OUTCLR = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;

  logic [WIDTH-1:0]    data_q,   data_d;
  logic [WIDTH-1:0]    blink_q,  blink_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q,    cnt_d;
  logic                phase_q,  phase_d;
  logic [WIDTH-1:0]    out_q,    out_d;

  logic                wr;
  logic                wr_data, wr_blink, wr_per, wr_set, wr_clr;
  logic [WIDTH-1:0]    wd_w;
  logic [PERIOD_W-1:0] wd_p;
  logic                tc;
  logic                unused_wd;

  assign wr       = chipselect & ~write_n;
  assign wr_data  = wr && (address == A_DATA);
  assign wr_blink = wr && (address == A_BLINK);
  assign wr_per   = wr && (address == A_PERIOD);
  assign wr_set   = wr && (address == A_OUTSET);
  assign wr_clr   = wr && (address == A_OUTCLR);

  assign wd_w = writedata[WIDTH-1:0];
  assign wd_p = writedata[PERIOD_W-1:0];

  // Bits above the field widths are intentionally dropped.
  assign unused_wd = ^writedata;

  // DATA: plain write, atomic set, atomic clear (one address per cycle).
  always_comb begin
    data_d = data_q;
    unique case (1'b1)
      wr_data: data_d = wd_w;
      wr_set:  data_d = data_q | wd_w;
      wr_clr:  data_d = data_q & ~wd_w;
      default: data_d = data_q;
    endcase
  end

  always_comb begin
    blink_d = blink_q;
    if (wr_blink) blink_d = wd_w;
  end

  always_comb begin
    period_d = period_q;
    if (wr_per) period_d = wd_p;
  end

  // Blink timer. A PERIOD write restarts the count and takes priority
  // over a coincident terminal count, so the phase holds that cycle.
  assign tc = (cnt_q == period_q);

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (wr_per) begin
      cnt_d = '0;
    end else if (tc) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Blinking bits are gated by phase; a blinking bit with DATA=0 stays 0.
  always_comb begin
    out_d = (data_q & ~blink_q)
          | (data_q & blink_q & {WIDTH{phase_q}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RST_DATA;
      blink_q  <= '0;
      period_q <= RST_PER;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      out_q    <= RST_DATA;
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
    end
  end

  assign out_port = out_q;

  // Zero-extended views of the readable registers.
  logic [31:0] data_x, blink_x, period_x, status_x;

  always_comb begin
    data_x               = '0;
    data_x[WIDTH-1:0]    = data_q;
    blink_x              = '0;
    blink_x[WIDTH-1:0]   = blink_q;
    period_x             = '0;
    period_x[PERIOD_W-1:0] = period_q;
    status_x             = '0;
    status_x[0]          = phase_q;
  end

  // Zero-wait-state read; reflects register state before any same-cycle write.
  always_comb begin
    readdata = '0;
    if (chipselect) begin
      unique case (address)
        A_DATA:   readdata = data_x;
        A_BLINK:  readdata = blink_x;
        A_PERIOD: readdata = period_x;
        A_STATUS: readdata = status_x;
        default:  readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_pio_led_blink.sv
// Testbench for nios2_pio_led_blink: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_nios2_pio_led_blink;

  localparam int          W   = 6;
  localparam logic [5:0]  RV  = 6'h15;
  localparam logic [23:0] DP  = 24'd2499999;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] out_port;

  nios2_pio_led_blink #(
    .WIDTH(W),
    .RESET_VALUE(32'h15),
    .PERIOD_W(24),
    .DEFAULT_PERIOD(32'd2499999)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model: the timer is described as elapsed cycles since the
  // last restart; phase = base XOR parity of completed half-periods.
  logic [5:0]  m_data   = RV;
  logic [5:0]  m_blink  = '0;
  logic [23:0] m_period = DP;
  logic        m_base   = 1'b0;
  longint      m_k      = 0;
  logic [5:0]  m_out    = RV;

  logic tb_wr;
  assign tb_wr = chipselect & ~write_n;

  function automatic logic m_phase();
    return m_base ^ (((m_k / (longint'(m_period) + 1)) % 2) != 0);
  endfunction

  function automatic longint m_cnt();
    return m_k % (longint'(m_period) + 1);
  endfunction

  function automatic logic [31:0] m_read();
    logic [31:0] r;
    r = '0;
    if (chipselect) begin
      case (address)
        3'd0: r = {26'b0, m_data};
        3'd1: r = {26'b0, m_blink};
        3'd2: r = {8'b0, m_period};
        3'd5: r = {31'b0, m_phase()};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_data   <= RV;
      m_blink  <= '0;
      m_period <= DP;
      m_base   <= 1'b0;
      m_k      <= 0;
      m_out    <= RV;
    end else begin
      m_out <= m_data & (~m_blink | {6{m_phase()}});
      if (tb_wr) begin
        case (address)
          3'd0: m_data  <= writedata[5:0];
          3'd1: m_blink <= writedata[5:0];
          3'd2: begin
            m_period <= writedata[23:0];
            m_base   <= m_phase();
          end
          3'd3: m_data <= m_data | writedata[5:0];
          3'd4: m_data <= m_data & ~writedata[5:0];
          default: ;
        endcase
      end
      if (tb_wr && address == 3'd2) m_k <= 0;
      else m_k <= m_k + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out_port", {26'b0, out_port}, {26'b0, m_out});
      check("model_readdata", readdata, m_read());
    end
  end

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    cyc();
    idle();
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a,
                        input logic [31:0] exp);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    #1;
    check(name, readdata, exp);
    cyc();
    idle();
  endtask

  logic [5:0] smp [24];
  logic       st  [8];
  logic       s0;
  int         last_t;
  int         gaps;
  int         guard;

  initial begin
    reset = 1'b1;
    idle();
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;

    // 1: reset state
    check("rst_out_port", {26'b0, out_port}, 32'h15);
    rd_chk("rst_data", 3'd0, 32'h15);
    rd_chk("rst_blink", 3'd1, 32'h0);
    rd_chk("rst_period", 3'd2, 32'd2499999);
    rd_chk("rst_status", 3'd5, 32'h0);

    // 2: data, set, clear
    wr(3'd0, 32'h3C);
    wr(3'd3, 32'h03);
    rd_chk("set_data", 3'd0, 32'h3F);
    wr(3'd4, 32'h30);
    check("clr_out_lag", {26'b0, out_port}, 32'h3F);
    rd_chk("clr_data", 3'd0, 32'h0F);
    check("clr_out", {26'b0, out_port}, 32'h0F);

    // 3: blink bit0 with PERIOD=3 -> 4-cycle half period
    wr(3'd2, 32'd3);
    wr(3'd1, 32'h01);
    wr(3'd0, 32'h03);
    for (int i = 0; i < 24; i++) begin
      smp[i] = out_port;
      cyc();
    end
    last_t = -1;
    gaps   = 0;
    for (int i = 2; i < 24; i++) begin
      check("blink_val", {31'b0, (smp[i] == 6'h02 || smp[i] == 6'h03)}, 32'h1);
      if (smp[i] != smp[i-1]) begin
        if (last_t >= 0) begin
          check("blink_gap", i - last_t, 32'd4);
          gaps++;
        end
        last_t = i;
      end
    end
    check("blink_ntoggles", {31'b0, gaps >= 3}, 32'h1);

    // 4: PERIOD=0 toggles every cycle; PERIOD write on terminal count
    wr(3'd2, 32'd0);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = 3'd5;
    for (int i = 0; i < 6; i++) begin
      #1;
      st[i] = readdata[0];
      if (i > 0) check("p0_toggle", {31'b0, st[i] ^ st[i-1]}, 32'h1);
      cyc();
    end
    #1;
    s0        = readdata[0];
    write_n   = 1'b0;
    address   = 3'd2;
    writedata = 32'd5;
    cyc();
    write_n = 1'b1;
    address = 3'd5;
    for (int j = 0; j < 6; j++) begin
      #1;
      check("tc_hold", {31'b0, readdata[0]}, {31'b0, s0});
      cyc();
    end
    #1;
    check("tc_next", {31'b0, readdata[0]}, {31'b0, ~s0});
    idle();
    cyc();

    // 5: ignored writes and reserved reads
    wr(3'd0, 32'h2A);
    chipselect = 1'b0;
    write_n    = 1'b0;
    address    = 3'd0;
    writedata  = 32'h15;
    cyc();
    idle();
    wr(3'd5, 32'h1);
    wr(3'd7, 32'h3F);
    rd_chk("cs0_data", 3'd0, 32'h2A);
    rd_chk("rd_a3", 3'd3, 32'h0);
    rd_chk("rd_a4", 3'd4, 32'h0);
    rd_chk("rd_a6", 3'd6, 32'h0);
    rd_chk("rd_a7", 3'd7, 32'h0);

    // 6: reset mid-blink with concurrent DATA write
    guard = 0;
    while (!(m_phase() && m_cnt() == 2) && guard < 100) begin
      cyc();
      guard++;
    end
    check("mid_blink_reached", {31'b0, guard < 100}, 32'h1);
    reset      = 1'b1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 3'd0;
    writedata  = 32'h3F;
    cyc();
    reset = 1'b0;
    idle();
    check("rst2_out", {26'b0, out_port}, 32'h15);
    rd_chk("rst2_data", 3'd0, 32'h15);
    rd_chk("rst2_status", 3'd5, 32'h0);
    rd_chk("rst2_period", 3'd2, 32'd2499999);

    // Random traffic against the model
    wr(3'd2, 32'd2);
    for (int n = 0; n < 1500; n++) begin
      reset      = ($urandom % 128) == 0;
      chipselect = ($urandom % 4) != 0;
      write_n    = ($urandom % 2) != 0;
      address    = 3'($urandom % 8);
      writedata  = $urandom;
      if (address == 3'd2)
        writedata = writedata & (($urandom % 2) ? 32'h7 : 32'hF);
      cyc();
    end
    reset = 1'b0;
    idle();
    cyc();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
